preset_sequencer: RTL
=====================

# preset_sequencer

Front-end controller for the preset-digit datapath: conditions the five push buttons and two switches, converts each press into a single command, arbitrates simultaneous commands by fixed priority, and owns the 3-bit preset `state` that selects the digit pattern shown on the four-digit display. The digit-pattern decode consumes `state` unchanged; this block sits between the board I/O pins and that decode.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a level change. The board build overrides it to 1_000_000. Legal range is 1 to 2^20.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btnU`, `btnL`, `btnR`, `btnD`, `btnC`  in  1 each  raw, asynchronous, bouncy push buttons.
- `sw`  in  2  raw slide switches. `sw[0]` is step-forward and `sw[1]` is step-back.
- `state`  out  3  current preset index, 0..6.
- `cmd_pulse`  out  1  high for exactly one cycle on the edge where `state` is (re)written.
- `cmd_id`  out  3  identifies the granted command. It is valid with `cmd_pulse` and holds its last value otherwise. Codes: 0 = C, 1 = D, 2 = R, 3 = L, 4 = U, 5 = FWD, 6 = BACK.
- `pending`  out  7  pending-request vector, bit index = `cmd_id`. It is visible for debug.

## Operation
- **Synchronizer.** Each of the 7 raw inputs passes through a 2-FF synchronizer.
- **Debouncer.** Each input has its own debouncer, made of a debounced level `db` and a counter.
  - If the synchronized sample equals `db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, `db` takes the sample and the counter clears.
- **Press detection.** A press is the rising edge of `db` (`db` 0→1, registered compare). Falling edges are ignored, and so are switches returned to 0.
- **Pending set.** A press sets the matching `pending` bit on the next edge. If a press arrives for a bit that is already set, it coalesces and no second command is produced.
- **Arbiter.**
  - Each cycle with `pending` ≠ 0, the lowest set index is granted. Priority is C > D > R > L > U > FWD > BACK.
  - The granted bit clears, `state` updates, `cmd_pulse` = 1 and `cmd_id` = the index, all on the same edge.
  - Only one grant happens per cycle.
  - If a new press sets a bit on the same edge that bit is granted, the set wins and the bit remains pending.
- **State update per command:**
  - C → 0.
  - D → 6.
  - R → 1.
  - L → 2.
  - U → 5.
  - FWD → (state+1) mod 5, computed unwrapped. This gives 0→1, 1→2, 2→3, 3→4, 4→0, 5→1, 6→2.
  - BACK → (state+4) mod 5, computed unwrapped. This gives 0→4, 1→0, 2→1, 3→2, 4→3, 5→4, 6→0.
- **Range.** `state` never holds 7.
- **Reset.**
  - Effects: `state` = 0, `cmd_pulse` = 0, `cmd_id` = 0, `pending` = 0, every `db` = 0, every counter = 0, every synchronizer FF = 0.
  - Mid-operation reset discards all pending and in-flight debounce progress.
  - An input held high through reset release is seen as a fresh press once it has been debounced after release.

## Timing
- Latency, with a raw input rising before edge E0 and stable thereafter:
  - The sync output is valid after E1.
  - `db` rises at E(1+N), where N = `DEBOUNCE_CYCLES`.
  - The `pending` bit sets at E(2+N).
  - If uncontested, `state`/`cmd_pulse` update at E(3+N). With N = 4 this is E7.
- Glitch rejection: a raw pulse shorter than N cycles (after sync) never changes `db`. With N = 4, a 3-cycle glitch produces no command.
- Contention: k simultaneous presses produce k `cmd_pulse` on k consecutive edges, in priority order.
- Throughput: at most one command per cycle, with no dead cycle between grants.
- `state` changes only on an edge with `cmd_pulse` = 1. A command that rewrites the same value still pulses.

## Test plan
1. **Reset.** Assert `rst` 2 cycles with all inputs 0 → `state` = 0, `pending` = 0, `cmd_pulse` = 0, and nothing changes for 50 cycles.
2. **Single FWD.** N = 4, raise `sw[0]` before E0 → `cmd_pulse` at E7 only, `cmd_id` = 5, `state` 0→1. Lower `sw[0]` → no pulse.
3. **Wrap-around.** Press D (state 6), then FWD → 2, then BACK → 1. Then press C, then BACK → 4, then FWD → 0.
4. **Bounce.** Toggle `btnR` with 1-, 2- and 3-cycle pulses, then hold it 10 cycles → exactly one pulse, `cmd_id` = 2, `state` = 1.
5. **Simultaneous.** Raise `btnU`, `btnL` and `btnC` on the same edge → three consecutive pulses with `cmd_id` 0, 3, 4; final `state` = 5.
6. **Reset mid-flight.** Raise `btnD`, assert `rst` at E(1+N) → no command, `state` = 0. Keep `btnD` high after release → one pulse N+3 edges after release, `state` = 6.

Source files
------------

// File: rtl/preset_sequencer.sv
// preset_sequencer: syncs and debounces 5 buttons and 2 switches, arbitrates presses by fixed priority, and owns the 3-bit preset state
module preset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnU,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnD,
    input  logic       btnC,
    input  logic [1:0] sw,
    output logic [2:0] state,
    output logic       cmd_pulse,
    output logic [2:0] cmd_id,
    output logic [6:0] pending
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES);

    logic [6:0]    raw, sync1_q, sync2_q, db_q, db_d, dbp_q, press;
    logic [CW-1:0] cnt_q [7];
    logic [CW-1:0] cnt_d [7];
    logic [6:0]    pending_q, pending_d;
    logic [2:0]    state_q, state_d, gid, fwd, back, cmd_id_q;
    logic [3:0]    ext;
    logic          cmd_pulse_q;

    assign raw       = {sw[1], sw[0], btnU, btnL, btnR, btnD, btnC};
    assign press     = db_q & ~dbp_q;
    assign ext       = {1'b0, state_q};
    assign fwd       = 3'((ext + 4'd1) % 4'd5);
    assign back      = 3'((ext + 4'd4) % 4'd5);
    assign pending_d = (pending_q & ~(7'd1 << gid)) | press;
    assign state     = state_q;
    assign cmd_pulse = cmd_pulse_q;
    assign cmd_id    = cmd_id_q;
    assign pending   = pending_q;

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] + CNT_ONE == CNT_LIM) db_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Lowest pending index wins: C > D > R > L > U > FWD > BACK
    always_comb begin
        gid = 3'd0;
        for (int i = 6; i >= 0; i--) if (pending_q[i]) gid = 3'(i);
    end

    // Preset value written by the granted command
    always_comb begin
        state_d = state_q;
        if (|pending_q) begin
            case (gid)
                3'd0:    state_d = 3'd0;
                3'd1:    state_d = 3'd6;
                3'd2:    state_d = 3'd1;
                3'd3:    state_d = 3'd2;
                3'd4:    state_d = 3'd5;
                3'd5:    state_d = fwd;
                default: state_d = back;
            endcase
        end
    end

    // Register synchronizers, debouncers, pending set and arbiter outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            dbp_q       <= '0;
            cnt_q       <= '{default: '0};
            pending_q   <= '0;
            state_q     <= '0;
            cmd_pulse_q <= 1'b0;
            cmd_id_q    <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            dbp_q       <= db_q;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            cmd_pulse_q <= |pending_q;
            if (|pending_q) cmd_id_q <= gid;
        end
    end
endmodule
